spikey_spi_shift: RTL and testbench
===================================

SPIKEY_SPI_SHIFT -- requirements
Module: spikey_spi_shift

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per transfer (legal 4..32).
REQ-002 SHALL have ports:
- FCLK  in  1  sole clock; all state updates on its rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- sck_pp  in  1  one-FCLK pulse from the divider marking an SCK rising-edge opportunity.
- sck_np  in  1  one-FCLK pulse from the divider marking an SCK falling-edge opportunity.
- tx_valid  in  1  transfer request.
- tx_ready  out  1  block can accept a request.
- tx_data  in  DATA_W  word to transmit, MSB first.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- rx_data  out  DATA_W  last received word.
- busy  out  1  high in any state other than IDLE.
- CS_N  out  1  SPI chip select, active-low.
- SCK  out  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- MOSI  out  1  SPI data out.
- MISO  in  1  SPI data in, assumed stable around SCK rise.

Function
REQ-003 SHALL implement FSM states IDLE, SETUP, XFER, HOLD; all outputs registered.
REQ-004 IDLE: tx_ready=1, CS_N=1, SCK=0, busy=0.
REQ-005 Handshake: tx_valid&tx_ready at FCLK edge latches tx_data into tx shift register, clears bit counter, enters SETUP next cycle; tx_data ignored at all other times.
REQ-006 SETUP: CS_N=0, MOSI=tx_shift[DATA_W-1], SCK=0; first sck_np pulse moves to XFER (guarantees >=half SCK period CS-to-SCK setup); sck_pp ignored.
REQ-007 XFER, SCK=0 and sck_pp: SCK<=1 and MISO shifted into LSB of rx shift register.
REQ-008 XFER, SCK=1 and sck_np: SCK<=0, bit counter+1; if counter reaches DATA_W go to HOLD, else tx shift left one bit and MOSI presents next bit.
REQ-009 Pulses inconsistent with current SCK level (sck_pp while SCK=1, sck_np while SCK=0) SHALL be ignored; simultaneous sck_pp and sck_np SHALL act only per REQ-007/008 on current SCK level.
REQ-010 HOLD: CS_N=0, SCK=0; next sck_pp moves to IDLE.
REQ-011 On HOLD->IDLE transition, rx_data<=rx shift register and rx_valid=1 for exactly the first IDLE cycle; rx_data holds until next completion.
REQ-012 A new request accepted in the same cycle rx_valid is high SHALL be legal (back-to-back), CS_N deasserted for at least one FCLK cycle between words.
REQ-013 Transfer SHALL produce exactly DATA_W SCK rising edges; MOSI SHALL change only on SCK falling edges or in SETUP.
REQ-014 Bit counter width clog2(DATA_W+1); no wrap within a transfer.
REQ-015 With no sck_pp/sck_np pulses the FSM SHALL stall in its current state with outputs stable.

Reset
REQ-016 RST_N low SHALL immediately force IDLE, CS_N=1, SCK=0, MOSI=0, tx_ready=0 while asserted, rx_valid=0, busy=0, rx_data=0, shift registers and counter cleared.
REQ-017 Reset mid-transfer SHALL abort with no rx_valid; first edge after RST_N release resumes in IDLE with tx_ready=1.

Verification
REQ-018 Scenario V1: DATA_W=8, pulses alternating np/pp every 4 FCLK, tx_data=0xA5, MISO driven from slave model returning 0x3C -> MOSI sequence 1,0,1,0,0,1,0,1; 8 SCK rises; rx_data=0x3C with single rx_valid; CS_N low only for the transfer.
REQ-019 Scenario V2: back-to-back 0xFF then 0x00, tx_valid held high -> second accepted on rx_valid cycle; CS_N high exactly 1 FCLK between words.
REQ-020 Scenario V3: RST_N pulsed low after 4th SCK rise of 0x81 -> CS_N=1, SCK=0 asynchronously; no rx_valid; subsequent 0x81 transfer completes correctly.
REQ-021 Scenario V4: pulses stopped for 50 FCLK mid-XFER, and injected sck_pp while SCK=1 -> no output change, no extra SCK edges; transfer completes with correct data after pulses resume.
REQ-022 Scenario V5: sck_pp and sck_np asserted together every cycle -> SCK toggles each qualifying cycle, exactly 8 rises, rx_data matches MISO pattern 0x96.

Source files
------------

// File: rtl/spikey_spi_shift.sv
`default_nettype none
// ============================================================================
//  Module      : spikey_spi_shift
//  Description : SPI mode-0 (CPOL=0, CPHA=0) master shift engine. A single
//                word of DATA_W bits is sent MSB first on MOSI while MISO is
//                captured into the receive shift register. SCK timing comes
//                entirely from an external divider through one-FCLK
//                pulses: sck_pp (rising-edge opportunity) and sck_np
//                (falling-edge opportunity). Every output is registered.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W    bits per transfer (4..32)
//  Ports
//    FCLK      in   1       sole clock, rising edge
//    RST_N     in   1       asynchronous active-low reset
//    sck_pp    in   1       SCK rising-edge opportunity pulse
//    sck_np    in   1       SCK falling-edge opportunity pulse
//    tx_valid  in   1       transfer request
//    tx_ready  out  1       request can be accepted (IDLE only)
//    tx_data   in   DATA_W  word to transmit, MSB first
//    rx_valid  out  1       one-cycle pulse, rx_data updated
//    rx_data   out  DATA_W  last received word
//    busy      out  1       engine is not in IDLE
//    CS_N      out  1       SPI chip select, active-low
//    SCK       out  1       SPI clock
//    MOSI      out  1       SPI data out
//    MISO      in   1       SPI data in, sampled on SCK rise
// ============================================================================
module spikey_spi_shift #(
  parameter int DATA_W = 8
) (
  input  logic              FCLK,
  input  logic              RST_N,
  input  logic              sck_pp,
  input  logic              sck_np,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              CS_N,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO
);

  // Counter must be able to hold DATA_W itself without wrapping.
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SETUP = 2'd1;
  localparam logic [1:0] c_XFER  = 2'd2;
  localparam logic [1:0] c_HOLD  = 2'd3;

  // Counter value before the increment that completes the word.
  localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic              r_sck;
  logic              r_mosi;
  logic              r_cs_n;
  logic              r_busy;
  logic              r_tx_ready;
  logic              r_rx_valid;
  logic [DATA_W-1:0] r_rx_data;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] r_rx_shift;
  logic [CNT_W-1:0]  r_cnt;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  logic [1:0]        w_state_nxt;
  logic              w_sck_nxt;
  logic              w_mosi_nxt;
  logic              w_rx_valid_nxt;
  logic [DATA_W-1:0] w_rx_data_nxt;
  logic [DATA_W-1:0] w_tx_shift_nxt;
  logic [DATA_W-1:0] w_rx_shift_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_accept;
  logic              w_rise;
  logic              w_fall;

  // Handshake qualified on the registered ready, so the cycle right after
  // reset release (ready still low) never accepts a request.
  assign w_accept = (r_state == c_IDLE) && tx_valid && r_tx_ready;

  // A pulse only counts when it matches the current SCK level; when both
  // pulses arrive together exactly one of these is true.
  assign w_rise = sck_pp && !r_sck;
  assign w_fall = sck_np &&  r_sck;

  always_comb begin
    w_state_nxt    = r_state;
    w_sck_nxt      = r_sck;
    w_mosi_nxt     = r_mosi;
    w_rx_valid_nxt = 1'b0;
    w_rx_data_nxt  = r_rx_data;
    w_tx_shift_nxt = r_tx_shift;
    w_rx_shift_nxt = r_rx_shift;
    w_cnt_nxt      = r_cnt;

    case (r_state)
      c_IDLE: begin
        w_sck_nxt = 1'b0;
        if (w_accept) begin
          w_tx_shift_nxt = tx_data;
          w_rx_shift_nxt = '0;
          w_cnt_nxt      = '0;
          // MSB is presented as CS_N falls, half a period before first rise.
          w_mosi_nxt     = tx_data[DATA_W-1];
          w_state_nxt    = c_SETUP;
        end
      end

      c_SETUP: begin
        // Waiting for a falling-edge opportunity gives at least half an SCK
        // period between CS_N assertion and the first SCK rise.
        if (sck_np) begin
          w_state_nxt = c_XFER;
        end
      end

      c_XFER: begin
        if (w_rise) begin
          w_sck_nxt      = 1'b1;
          w_rx_shift_nxt = {r_rx_shift[DATA_W-2:0], MISO};
        end else if (w_fall) begin
          w_sck_nxt = 1'b0;
          w_cnt_nxt = r_cnt + c_CNT_ONE;
          if (r_cnt == c_LAST_BIT) begin
            // Last bit done: MOSI stays put, no further shifting.
            w_state_nxt = c_HOLD;
          end else begin
            w_tx_shift_nxt = {r_tx_shift[DATA_W-2:0], 1'b0};
            w_mosi_nxt     = r_tx_shift[DATA_W-2];
          end
        end
      end

      c_HOLD: begin
        // CS_N is held through one more rising-edge opportunity so the last
        // bit has a full hold time before deselect.
        if (sck_pp) begin
          w_state_nxt    = c_IDLE;
          w_rx_data_nxt  = r_rx_shift;
          w_rx_valid_nxt = 1'b1;
          w_mosi_nxt     = 1'b0;
        end
      end

      default: begin
        w_state_nxt = c_IDLE;
        w_sck_nxt   = 1'b0;
        w_mosi_nxt  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers. Status outputs are derived from the next state so that they
  // line up exactly with the state they describe.
  // --------------------------------------------------------------------------
  always_ff @(posedge FCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= c_IDLE;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_tx_ready <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sck      <= w_sck_nxt;
      r_mosi     <= w_mosi_nxt;
      r_cs_n     <= (w_state_nxt == c_IDLE);
      r_busy     <= (w_state_nxt != c_IDLE);
      r_tx_ready <= (w_state_nxt == c_IDLE);
      r_rx_valid <= w_rx_valid_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign tx_ready = r_tx_ready;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign busy     = r_busy;
  assign CS_N     = r_cs_n;
  assign SCK      = r_sck;
  assign MOSI     = r_mosi;

endmodule
`default_nettype wire

// File: tb/tb_spikey_spi_shift.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spikey_spi_shift
//  Description : Self-checking bench for spikey_spi_shift. A behavioural SPI
//                slave answers on MISO and records MOSI at every SCK rise;
//                each transfer is judged against the word sent, the slave's
//                word and the expected count of SCK rises.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spikey_spi_shift;

  localparam int W = 8;

  logic         FCLK = 1'b0;
  logic         RST_N;
  logic         sck_pp;
  logic         sck_np;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] tx_data = '0;
  logic         rx_valid;
  logic [W-1:0] rx_data;
  logic         busy;
  logic         CS_N;
  logic         SCK;
  logic         MOSI;
  logic         MISO = 1'b0;

  spikey_spi_shift #(.DATA_W(W)) dut (
    .FCLK    (FCLK),
    .RST_N   (RST_N),
    .sck_pp  (sck_pp),
    .sck_np  (sck_np),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx_data (tx_data),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .busy    (busy),
    .CS_N    (CS_N),
    .SCK     (SCK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  always #5 FCLK = ~FCLK;

  int checks = 0;
  int errors = 0;

  // Divider model: 0 alternating np/pp every 4 cycles, 1 stopped (with
  // optional single injected sck_pp), 2 both every cycle, 3 random pulses.
  int pmode    = 0;
  int inj_req  = 0;
  int inj_done = 0;
  int p_div    = 0;
  bit p_ph     = 1'b0;

  // Slave model and observation state.
  logic [W-1:0] slave_word = '0;
  int   rises     = 0;
  int   rxv       = 0;
  int   sidx      = 0;
  int   cs_hi_run = 0;
  int   last_gap  = -1;
  logic p_sck     = 1'b0;
  logic p_cs      = 1'b1;
  logic p_mosi    = 1'b0;
  bit   mosi_q[$];

  int   r0, q0, v0, n, rs;
  logic [3:0]   snap;
  logic [W-1:0] tw, sw, s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One FCLK cycle: sample at the falling edge and update the slave model.
  task automatic tick();
    logic rise, fall;
    @(negedge FCLK);
    rise = !p_sck && SCK;
    fall = p_sck && !SCK;
    if (rise) begin
      rises++;
      mosi_q.push_back(MOSI);
    end
    if (CS_N) begin
      sidx = 0;
      cs_hi_run++;
    end else begin
      if (p_cs) last_gap = cs_hi_run;
      cs_hi_run = 0;
      if (fall) sidx++;
    end
    if (rx_valid) rxv++;
    // MOSI may only move on an SCK fall while the slave is selected.
    if (!CS_N && !p_cs && (MOSI !== p_mosi)) chk("mosi_change_on_fall", {31'd0, fall}, 1);
    chk("sck_low_while_deselected", {31'd0, SCK & CS_N}, 0);
    MISO   = (sidx < W) ? slave_word[W-1-sidx] : 1'b0;
    p_sck  = SCK;
    p_cs   = CS_N;
    p_mosi = MOSI;
  endtask

  task automatic snapshot();
    r0 = rises;
    q0 = mosi_q.size();
    v0 = rxv;
  endtask

  task automatic send(input logic [W-1:0] w, input bit keep);
    int k = 0;
    tx_data  = w;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk("send_ready_seen", {31'd0, tx_ready}, 1);
    tick();
    chk("send_busy", {31'd0, busy}, 1);
    chk("send_cs_low", {31'd0, CS_N}, 0);
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [W-1:0] etx, input logic [W-1:0] erx);
    int k = 0;
    logic [W-1:0] got = '0;
    while (rx_valid !== 1'b1 && k < 3000) begin
      tick();
      k++;
    end
    chk("done_rx_valid", {31'd0, rx_valid}, 1);
    chk("done_rx_data", 32'(rx_data), 32'(erx));
    chk("done_sck_rises", rises - r0, W);
    for (int i = 0; i < W; i++)
      if (q0 + i < mosi_q.size()) got[W-1-i] = mosi_q[q0+i];
    chk("done_mosi_word", 32'(got), 32'(etx));
    chk("done_single_rx_valid", rxv - v0, 1);
    chk("done_cs_high", {31'd0, CS_N}, 1);
    chk("done_not_busy", {31'd0, busy}, 0);
  endtask

  // Pulse generator standing in for the SCK divider.
  initial begin
    sck_pp = 1'b0;
    sck_np = 1'b0;
    forever begin
      @(negedge FCLK);
      sck_pp = 1'b0;
      sck_np = 1'b0;
      case (pmode)
        0: begin
          p_div++;
          if (p_div >= 4) begin
            p_div = 0;
            if (p_ph) sck_pp = 1'b1;
            else      sck_np = 1'b1;
            p_ph = !p_ph;
          end
        end
        2: begin
          sck_pp = 1'b1;
          sck_np = 1'b1;
        end
        3: begin
          sck_pp = ($urandom_range(0, 2) == 0);
          sck_np = ($urandom_range(0, 2) == 0);
        end
        default: begin
          if (inj_req != inj_done) begin
            sck_pp   = 1'b1;
            inj_done = inj_req;
          end
        end
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    repeat (3) tick();
    chk("rst_cs_n", {31'd0, CS_N}, 1);
    chk("rst_sck", {31'd0, SCK}, 0);
    chk("rst_mosi", {31'd0, MOSI}, 0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    RST_N = 1'b1;
    tick();
    chk("post_rst_ready", {31'd0, tx_ready}, 1);
    chk("post_rst_cs_n", {31'd0, CS_N}, 1);

    // V1: 0xA5 out, slave returns 0x3C.
    pmode = 0;
    slave_word = 8'h3C;
    snapshot();
    send(8'hA5, 1'b0);
    wait_done(8'hA5, 8'h3C);
    tick();
    chk("v1_rx_valid_drop", {31'd0, rx_valid}, 0);
    chk("v1_rx_data_hold", 32'(rx_data), 32'h3C);

    // V2: back-to-back 0xFF then 0x00 with tx_valid held high.
    sw = 8'($urandom);
    s2 = 8'($urandom);
    slave_word = sw;
    snapshot();
    send(8'hFF, 1'b1);
    tx_data = 8'h00;
    wait_done(8'hFF, sw);
    chk("v2_ready_on_rx_valid", {31'd0, tx_ready}, 1);
    slave_word = s2;
    snapshot();
    tick();
    chk("v2_second_accepted", {31'd0, CS_N}, 0);
    chk("v2_busy", {31'd0, busy}, 1);
    chk("v2_cs_gap", last_gap, 1);
    tx_valid = 1'b0;
    wait_done(8'h00, s2);
    tick();
    chk("v2_rx_valid_drop", {31'd0, rx_valid}, 0);

    // V3: reset after the 4th SCK rise of 0x81, then a clean 0x81.
    slave_word = 8'($urandom);
    snapshot();
    send(8'h81, 1'b0);
    n = 0;
    while (rises - r0 < 4 && n < 2000) begin
      tick();
      n++;
    end
    chk("v3_fourth_rise_sck_high", {31'd0, SCK}, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("v3_async_cs_n", {31'd0, CS_N}, 1);
    chk("v3_async_sck", {31'd0, SCK}, 0);
    chk("v3_async_busy", {31'd0, busy}, 0);
    chk("v3_async_mosi", {31'd0, MOSI}, 0);
    chk("v3_async_rx_data", 32'(rx_data), 0);
    tick();
    tick();
    chk("v3_ready_low_in_reset", {31'd0, tx_ready}, 0);
    chk("v3_no_rx_valid", rxv - v0, 0);
    RST_N = 1'b1;
    tick();
    chk("v3_resume_ready", {31'd0, tx_ready}, 1);
    sw = 8'($urandom);
    slave_word = sw;
    snapshot();
    send(8'h81, 1'b0);
    wait_done(8'h81, sw);

    // V4: stall mid-transfer with SCK high, inject a stray sck_pp.
    tw = 8'($urandom);
    sw = 8'($urandom);
    slave_word = sw;
    snapshot();
    send(tw, 1'b0);
    n = 0;
    while (!(rises - r0 >= 3 && SCK === 1'b1) && n < 2000) begin
      tick();
      n++;
    end
    pmode = 1;
    tick();
    chk("v4_sck_high_at_stall", {31'd0, SCK}, 1);
    snap = {SCK, CS_N, MOSI, busy};
    rs = rises;
    inj_req++;
    repeat (50) begin
      tick();
      chk("v4_outputs_stable", 32'({SCK, CS_N, MOSI, busy}), 32'(snap));
    end
    chk("v4_injected", inj_done, inj_req);
    chk("v4_no_extra_rise", rises - rs, 0);
    pmode = 0;
    wait_done(tw, sw);

    // V5: both pulses every cycle, slave pattern 0x96.
    pmode = 2;
    tw = 8'($urandom);
    slave_word = 8'h96;
    snapshot();
    send(tw, 1'b0);
    wait_done(tw, 8'h96);
    tick();

    // Random words under assorted pulse patterns.
    for (int t = 0; t < 6; t++) begin
      case ($urandom_range(0, 2))
        0:       pmode = 0;
        1:       pmode = 2;
        default: pmode = 3;
      endcase
      tw = 8'($urandom);
      sw = 8'($urandom);
      slave_word = sw;
      snapshot();
      send(tw, 1'b0);
      wait_done(tw, sw);
      tick();
      chk("rand_rx_valid_drop", {31'd0, rx_valid}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
